// File: rtl/regbus_arb_pkg.sv
// Shared types and constants for the register-bus arbiter.
// Holds the FSM state encoding and the timeout read-data value.
package regbus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_e;

  localparam logic [31:0] TIMEOUT_RDATA      = 32'hDEADDEAD;
  localparam int          TIMEOUT_CYCLES_DEF = 7;

endpackage

// File: rtl/regbus_arbiter_if.sv
// Requester-side and downstream register-bus signals of the arbiter.
// slave = arbiter view, master = requesters/slave-fabric view.
interface regbus_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
);
  localparam int IW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]             Req_addr_valid;
  logic [NUM_REQ-1:0]             Req_reg_write;
  logic [NUM_REQ-1:0][ADDR_W-1:0] Req_reg_addr;
  logic [NUM_REQ-1:0][DATA_W-1:0] Req_reg_wdata;
  logic [NUM_REQ-1:0]             Req_reg_ready;
  logic [DATA_W-1:0]              Req_reg_rdata;
  logic                           Req_timeout;
  logic                           Regbus_addr_valid;
  logic                           Regbus_reg_write;
  logic [ADDR_W-1:0]              Regbus_reg_addr;
  logic [DATA_W-1:0]              Regbus_reg_wdata;
  logic                           Regbus_reg_ready;
  logic [DATA_W-1:0]              Regbus_reg_rdata;
  logic [IW-1:0]                  Grant_idx;

  modport slave (
    input  Req_addr_valid, Req_reg_write,
    input  Req_reg_addr, Req_reg_wdata,
    output Req_reg_ready, Req_reg_rdata,
    output Req_timeout,
    output Regbus_addr_valid, Regbus_reg_write,
    output Regbus_reg_addr, Regbus_reg_wdata,
    input  Regbus_reg_ready, Regbus_reg_rdata,
    output Grant_idx
  );

  modport master (
    output Req_addr_valid, Req_reg_write,
    output Req_reg_addr, Req_reg_wdata,
    input  Req_reg_ready, Req_reg_rdata,
    input  Req_timeout,
    input  Regbus_addr_valid, Regbus_reg_write,
    input  Regbus_reg_addr, Regbus_reg_wdata,
    output Regbus_reg_ready, Regbus_reg_rdata,
    input  Grant_idx
  );

endinterface

// File: rtl/regbus_arbiter_rr_arbiter.sv
// Combinational round-robin pick: search starts one past last
// and wraps modulo NUM_REQ.
module rr_arbiter #(
  parameter int NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] last,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [$clog2(NUM_REQ)-1:0] idx,
  output logic                       any
);
  localparam int IW = $clog2(NUM_REQ);

  logic [IW-1:0] ci;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    ci  = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      ci = IW'((int'(last) + i) % NUM_REQ);
      if (!any && req[ci]) begin
        any     = 1'b1;
        gnt[ci] = 1'b1;
        idx     = ci;
      end
    end
  end

endmodule

// File: rtl/regbus_arbiter.sv
// Round-robin register-bus arbiter, one outstanding transaction.
// Macro REGBUS_ARB_TIMEOUT_EN enables the BUSY timeout.
module regbus_arbiter
  import regbus_arb_pkg::*;
#(
  parameter int NUM_REQ        = 3,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input logic             Clk,
  input logic             Rst,
  regbus_arbiter_if.slave bus
);
  localparam int IW = $clog2(NUM_REQ);

  state_e             state_q, state_d;
  logic [IW-1:0]      last_q, last_d;
  logic [IW-1:0]      gidx_q, gidx_d;
  logic [NUM_REQ-1:0] oh_q, oh_d;
  logic [NUM_REQ-1:0] rdy_q, rdy_d;
  logic               val_q, val_d;
  logic               wr_q, wr_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic [NUM_REQ-1:0] win_oh;
  logic [IW-1:0]      win_idx;
  logic               win_any;
  logic               to_hit;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req  (bus.Req_addr_valid),
    .last (last_q),
    .gnt  (win_oh),
    .idx  (win_idx),
    .any  (win_any)
  );

`ifdef REGBUS_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          to_q, to_d;
  assign to_hit          = (cnt_q == CW'(TIMEOUT_CYCLES));
  assign bus.Req_timeout = to_q;
`else
  logic [31:0] unused_timeout;
  assign unused_timeout  = 32'(TIMEOUT_CYCLES);
  assign to_hit          = 1'b0;
  assign bus.Req_timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gidx_d  = gidx_q;
    oh_d    = oh_q;
    rdy_d   = '0;
    val_d   = val_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
`ifdef REGBUS_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    to_d    = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (win_any) begin
          wr_d    = bus.Req_reg_write[win_idx];
          addr_d  = bus.Req_reg_addr[win_idx];
          wdata_d = bus.Req_reg_wdata[win_idx];
          val_d   = 1'b1;
          last_d  = win_idx;
          gidx_d  = win_idx;
          oh_d    = win_oh;
`ifdef REGBUS_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
          state_d = BUSY;
        end
      end
      BUSY: begin
`ifdef REGBUS_ARB_TIMEOUT_EN
        cnt_d = cnt_q + 1'b1;
`endif
        // A real ready beats a coincident timeout.
        if (bus.Regbus_reg_ready) begin
          rdata_d = wr_q ? '0 : bus.Regbus_reg_rdata;
          val_d   = 1'b0;
          rdy_d   = oh_q;
          state_d = RESP;
        end else if (to_hit) begin
          rdata_d = wr_q ? '0 : DATA_W'(TIMEOUT_RDATA);
          val_d   = 1'b0;
          rdy_d   = oh_q;
`ifdef REGBUS_ARB_TIMEOUT_EN
          to_d    = 1'b1;
`endif
          state_d = RESP;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= IDLE;
      last_q  <= IW'(NUM_REQ - 1);
      gidx_q  <= '0;
      oh_q    <= '0;
      rdy_q   <= '0;
      val_q   <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
`ifdef REGBUS_ARB_TIMEOUT_EN
      cnt_q   <= '0;
      to_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gidx_q  <= gidx_d;
      oh_q    <= oh_d;
      rdy_q   <= rdy_d;
      val_q   <= val_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
`ifdef REGBUS_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
      to_q    <= to_d;
`endif
    end
  end

  assign bus.Req_reg_ready     = rdy_q;
  assign bus.Req_reg_rdata     = rdata_q;
  assign bus.Regbus_addr_valid = val_q;
  assign bus.Regbus_reg_write  = wr_q;
  assign bus.Regbus_reg_addr   = addr_q;
  assign bus.Regbus_reg_wdata  = wdata_q;
  assign bus.Grant_idx         = gidx_q;

endmodule

// File: tb/tb_regbus_arbiter.sv
// Directed bench for regbus_arbiter: vector table plus
// hand sequences for timeout, reset and round-robin order.
module tb_regbus_arbiter;
  localparam int NR = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regbus_arbiter_if #(
    .NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)
  ) bus ();

  regbus_arbiter #(
    .NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .Clk (clk),
    .Rst (rst),
    .bus (bus)
  );

  // Slave model: ready after slv_lat wait cycles; -1 = silent.
  int          slv_lat = -1;
  logic [31:0] slv_data = '0;
  int          slv_cnt = 0;

  always @(posedge clk) begin
    if (rst || !bus.Regbus_addr_valid || bus.Regbus_reg_ready)
      slv_cnt <= 0;
    else
      slv_cnt <= slv_cnt + 1;
  end

  assign bus.Regbus_reg_ready = bus.Regbus_addr_valid &&
    (slv_lat >= 0) && (slv_cnt == slv_lat);
  assign bus.Regbus_reg_rdata =
    bus.Regbus_reg_ready ? slv_data : 32'h0;

  int errs = 0;
  int checks = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  typedef struct {
    int          req;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] sdata;
    int          exp_n;
    logic [31:0] exp_rdata;
    logic        exp_to;
  } vec_t;

  vec_t vecs[4];

  // Results of one transaction observed by run_txn.
  int          r_n, r_vc, r_vcnt;
  logic        r_got, r_wr, r_to;
  logic [31:0] r_addr, r_wdata, r_rdata;
  logic [NR-1:0] r_rdy;
  logic [1:0]  r_gidx;

  task automatic start_req(input int r, input logic wr,
                           input logic [31:0] a,
                           input logic [31:0] d);
    bus.Req_addr_valid[r] = 1'b1;
    bus.Req_reg_write[r]  = wr;
    bus.Req_reg_addr[r]   = a;
    bus.Req_reg_wdata[r]  = d;
  endtask

  task automatic run_txn(input int limit);
    logic seen;
    seen   = 1'b0;
    r_got  = 1'b0;
    r_n    = 0;
    r_vc   = 0;
    r_vcnt = 0;
    for (int c = 1; c <= limit && !r_got; c++) begin
      @(negedge clk);
      if (bus.Regbus_addr_valid) r_vcnt++;
      if (!seen && bus.Regbus_addr_valid) begin
        seen    = 1'b1;
        r_vc    = c;
        r_wr    = bus.Regbus_reg_write;
        r_addr  = bus.Regbus_reg_addr;
        r_wdata = bus.Regbus_reg_wdata;
        r_gidx  = bus.Grant_idx;
      end
      if (bus.Req_reg_ready != '0) begin
        r_got   = 1'b1;
        r_n     = c;
        r_rdy   = bus.Req_reg_ready;
        r_rdata = bus.Req_reg_rdata;
        r_to    = bus.Req_timeout;
      end
    end
    bus.Req_addr_valid = '0;
  endtask

  initial begin
    int   ng, lastc;
    logic pv, stray;

    bus.Req_addr_valid = '0;
    bus.Req_reg_write  = '0;
    bus.Req_reg_addr   = '0;
    bus.Req_reg_wdata  = '0;

    vecs[0] = '{0, 1'b0, 32'h10, 32'h0, 2, 32'h12345678,
                4, 32'h12345678, 1'b0};
    vecs[1] = '{2, 1'b1, 32'h40, 32'hCAFEF00D, 0, 32'h55AA55AA,
                2, 32'h0, 1'b0};
    vecs[2] = '{1, 1'b0, 32'h20, 32'h0, 0, 32'hA5A50001,
                2, 32'hA5A50001, 1'b0};
    vecs[3] = '{0, 1'b0, 32'h24, 32'h0, TO, 32'h0BADF00D,
                TO + 2, 32'h0BADF00D, 1'b0};

    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(bus.Regbus_addr_valid), 32'h0);
    chk("rst_write", 32'(bus.Regbus_reg_write), 32'h0);
    chk("rst_addr", bus.Regbus_reg_addr, 32'h0);
    chk("rst_wdata", bus.Regbus_reg_wdata, 32'h0);
    chk("rst_ready", 32'(bus.Req_reg_ready), 32'h0);
    chk("rst_rdata", bus.Req_reg_rdata, 32'h0);
    chk("rst_timeout", 32'(bus.Req_timeout), 32'h0);
    chk("rst_gidx", 32'(bus.Grant_idx), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) begin
      slv_lat  = vecs[i].lat;
      slv_data = vecs[i].sdata;
      start_req(vecs[i].req, vecs[i].wr,
                vecs[i].addr, vecs[i].wdata);
      run_txn(40);
      chk("v_got", 32'(r_got), 32'h1);
      chk("v_lat", 32'(r_n), 32'(vecs[i].exp_n));
      chk("v_grant_cyc", 32'(r_vc), 32'h1);
      chk("v_dn_write", 32'(r_wr), 32'(vecs[i].wr));
      chk("v_dn_addr", r_addr, vecs[i].addr);
      chk("v_dn_wdata", r_wdata, vecs[i].wdata);
      chk("v_gidx", 32'(r_gidx), 32'(vecs[i].req));
      chk("v_ready", 32'(r_rdy), 32'(1 << vecs[i].req));
      chk("v_rdata", r_rdata, vecs[i].exp_rdata);
      chk("v_timeout", 32'(r_to), 32'(vecs[i].exp_to));
      @(negedge clk);
      chk("v_ready_pulse", 32'(bus.Req_reg_ready), 32'h0);
    end

    // Silent slave.
    slv_lat = -1;
    start_req(1, 1'b0, 32'h30, 32'h0);
    run_txn(110);
`ifdef REGBUS_ARB_TIMEOUT_EN
    chk("to_rd_lat", 32'(r_n), 32'(TO + 2));
    chk("to_rd_vcnt", 32'(r_vcnt), 32'(TO + 1));
    chk("to_rd_ready", 32'(r_rdy), 32'h2);
    chk("to_rd_rdata", r_rdata, 32'hDEADDEAD);
    chk("to_rd_flag", 32'(r_to), 32'h1);
    @(negedge clk);
    chk("to_flag_pulse", 32'(bus.Req_timeout), 32'h0);
    start_req(2, 1'b1, 32'h44, 32'h12121212);
    run_txn(40);
    chk("to_wr_lat", 32'(r_n), 32'(TO + 2));
    chk("to_wr_rdata", r_rdata, 32'h0);
    chk("to_wr_flag", 32'(r_to), 32'h1);
    @(negedge clk);
`else
    chk("hang_no_ready", 32'(r_got), 32'h0);
    chk("hang_valid", 32'(bus.Regbus_addr_valid), 32'h1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
`endif

    // Reset in the second BUSY cycle.
    start_req(1, 1'b0, 32'h50, 32'h0);
    repeat (2) @(negedge clk);
    chk("mid_busy", 32'(bus.Regbus_addr_valid), 32'h1);
    rst = 1'b1;
    bus.Req_addr_valid = '0;
    @(negedge clk);
    chk("mid_valid", 32'(bus.Regbus_addr_valid), 32'h0);
    chk("mid_ready", 32'(bus.Req_reg_ready), 32'h0);
    chk("mid_addr", bus.Regbus_reg_addr, 32'h0);
    chk("mid_gidx", 32'(bus.Grant_idx), 32'h0);
    rst = 1'b0;
    stray = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (bus.Req_reg_ready != '0) stray = 1'b1;
    end
    chk("mid_no_ack", 32'(stray), 32'h0);

    // All three requesting, zero-wait slave.
    slv_lat  = 0;
    slv_data = 32'h77;
    for (int r = 0; r < NR; r++)
      start_req(r, 1'b0, 32'h100 + 32'(r * 4), 32'h0);
    ng    = 0;
    lastc = 0;
    pv    = 1'b0;
    for (int c = 1; c <= 40 && ng < 6; c++) begin
      @(negedge clk);
      if (bus.Regbus_addr_valid && !pv) begin
        chk("rr_gidx", 32'(bus.Grant_idx), 32'(ng % NR));
        chk("rr_addr", bus.Regbus_reg_addr,
            32'h100 + 32'((ng % NR) * 4));
        if (ng == 0)
          chk("rr_first_cyc", 32'(c), 32'h1);
        else
          chk("rr_gap", 32'(c - lastc), 32'h3);
        lastc = c;
        ng++;
      end
      pv = bus.Regbus_addr_valid;
    end
    chk("rr_count", 32'(ng), 32'h6);
    bus.Req_addr_valid = '0;
    repeat (4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/regbus_arbiter.md
# regbus_arbiter

Shares one register-bus slave port among NUM_REQ register-bus requesters, for example the AXI4-Lite bridge, a debug or JTAG master and the on-chip miner control sequencer. Arbitration is round-robin with one outstanding transaction at a time. Each transaction is guarded by a timeout that returns 32'hDEADDEAD on a read. The block sits between the requesters and the register decode fabric.

## Interface
Parameters:
- NUM_REQ, 3: number of requesters, 2..8
- ADDR_W, 32: register address width
- DATA_W, 32: register data width
- TIMEOUT_CYCLES, 7: cycles spent in BUSY without reg_ready before a forced completion

Ports:
- Clk  in  1  clock; one clock domain only
- Rst  in  1  synchronous, active-high reset
- Req_addr_valid  in  NUM_REQ  per-requester request; held high until that requester's Req_reg_ready
- Req_reg_write  in  NUM_REQ  1 = write, 0 = read
- Req_reg_addr  in  NUM_REQ x ADDR_W  request address
- Req_reg_wdata  in  NUM_REQ x DATA_W  write data
- Req_reg_ready  out  NUM_REQ  one-cycle completion pulse, one-hot
- Req_reg_rdata  out  DATA_W  read data, broadcast; valid while Req_reg_ready is high
- Req_timeout  out  1  pulses together with a Req_reg_ready that was forced by timeout
- Regbus_addr_valid  out  1  downstream request
- Regbus_reg_write  out  1  downstream direction
- Regbus_reg_addr  out  ADDR_W  downstream address
- Regbus_reg_wdata  out  DATA_W  downstream write data
- Regbus_reg_ready  in  1  downstream completion, one-cycle pulse
- Regbus_reg_rdata  in  DATA_W  downstream read data, valid with Regbus_reg_ready
- Grant_idx  out  $clog2(NUM_REQ)  index of the current or last granted requester (debug)

## Operation
State machine: IDLE, BUSY, RESP.
- **IDLE**
  - If any Req_addr_valid is high, pick the winner round-robin: search starts at last_grant+1 and wraps modulo NUM_REQ.
  - Register the winner's write/addr/wdata onto the Regbus outputs.
  - Set Regbus_addr_valid=1, update last_grant and Grant_idx, clear the timeout counter, go to BUSY.
- **BUSY**
  - Regbus_addr_valid stays 1 and the counter increments each cycle.
  - On Regbus_reg_ready:
    - capture Regbus_reg_rdata (reads only; on writes the capture register is loaded with 0);
    - drive Regbus_addr_valid=0 and go to RESP.
  - Timeout: if counter==TIMEOUT_CYCLES and Regbus_reg_ready is low:
    - capture 32'hDEADDEAD for a read, 0 for a write;
    - set the timeout flag, drive Regbus_addr_valid=0, go to RESP.
  - Ready and timeout in the same cycle: ready wins and no timeout flag is set.
- **RESP**
  - Req_reg_ready[winner]=1 for exactly one cycle, with Req_reg_rdata = the captured value.
  - Req_timeout = the timeout flag.
  - Go to IDLE.
- Regbus_reg_ready outside BUSY is ignored.
- A requester dropping Req_addr_valid before completion is a protocol violation: the transaction still completes and is still acknowledged.
- Address and data are latched at grant, so requester changes after grant have no effect.
- Counter width is $clog2(TIMEOUT_CYCLES+1). It never wraps because it is cleared on grant.

## Timing
- Reset values:
  - all outputs 0 (Regbus_*, Req_reg_ready, Req_reg_rdata, Req_timeout, Grant_idx);
  - state IDLE;
  - last_grant = NUM_REQ-1, so requester 0 has first priority.
- Rst asserted mid-transaction: the transaction is abandoned, no Req_reg_ready is issued and the downstream request drops on the next edge.
- Request in IDLE at cycle 0 -> Regbus_addr_valid high at cycle 1.
- Regbus_reg_ready at cycle k -> Req_reg_ready at k+1 -> IDLE at k+2 -> next grant visible downstream at k+3.
- Throughput: one transaction per 3 cycles minimum, at a zero-wait slave.
- Timeout with no ready ever: Regbus_addr_valid high for cycles 1..TIMEOUT_CYCLES+1, Req_reg_ready at TIMEOUT_CYCLES+2.
- Requesters deassert Req_addr_valid on the edge after they see Req_reg_ready, so IDLE never re-grants a completed request.

## Configuration
- Macro REGBUS_ARB_TIMEOUT_EN.
- **Defined:** the timeout counter and forced completion are as described above.
- **Undefined:**
  - the counter and timeout logic are removed;
  - BUSY waits indefinitely for Regbus_reg_ready;
  - Req_timeout is tied to 0;
  - TIMEOUT_CYCLES is ignored.

## Structure
- Package regbus_arb_pkg holds:
  - the state enum (IDLE, BUSY, RESP);
  - the timeout read-data constant, value 32'hDEADDEAD;
  - the default TIMEOUT_CYCLES.
- Sub-module rr_arbiter:
  - combinational round-robin winner selection from the request vector and last_grant;
  - outputs a one-hot grant and a winner index;
  - parameterised by NUM_REQ.

## Test plan
- Single read, req 0, addr 0x10, slave returns 0x12345678 after 2 cycles -> Regbus_addr_valid cycles 1..3, Req_reg_ready[0] at cycle 4 with rdata 0x12345678, Req_timeout=0.
- All three requesters valid continuously, zero-wait slave -> grants in order 0,1,2,0,1,2 and Grant_idx follows; each grant is 3 cycles apart.
- Write from req 2, addr 0x40, wdata 0xCAFEF00D -> downstream carries write=1, addr 0x40, wdata 0xCAFEF00D; Req_reg_ready[2] pulses once.
- Read with a silent slave, TIMEOUT_CYCLES=7 -> Req_reg_ready at cycle 9, rdata 0xDEADDEAD, Req_timeout=1; build without REGBUS_ARB_TIMEOUT_EN -> no completion within 100 cycles.
- Regbus_reg_ready on exactly the timeout cycle -> real rdata is returned and Req_timeout=0.
- Rst asserted in BUSY cycle 2 -> all outputs 0 next cycle, no Req_reg_ready; after release the first grant goes to requester 0.
